// File: rtl/inst_rom_loader.sv
// Boot-loadable instruction ROM: holds the core in reset while a big-endian header+payload
// byte stream fills the word array, then serves combinational fetches. Optional trailer: INST_ROM_CKSUM_EN.
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_start,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_data,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        core_rst_o,
  output logic        load_done_o,
  output logic        load_err_o,
  output logic [15:0] words_loaded_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

`ifdef INST_ROM_CKSUM_EN
  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_RUN, S_CKS, S_ERR} state_t;
  localparam state_t S_DONE = S_CKS;
`else
  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_RUN} state_t;
  localparam state_t S_DONE = S_RUN;
`endif

  state_t      state_reg, state_next;
  logic [15:0] count_reg;   // N: words announced in the header
  logic [15:0] widx_reg;    // words received so far, including suppressed ones
  logic [1:0]  lane_reg;
  logic [23:0] shift_reg;
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        last_byte;
  logic        last_word;
  logic        wr_en;
  logic [15:0] n_full;

  assign ld_ready  = (state_reg != S_RUN)
`ifdef INST_ROM_CKSUM_EN
                     && (state_reg != S_ERR)
`endif
                     ;
  assign accept    = ld_valid && ld_ready;
  assign last_byte = (lane_reg == 2'd3);
  assign last_word = ((widx_reg + 16'd1) == count_reg);
  assign n_full    = {count_reg[15:8], ld_data};
  // Words past the array end are consumed but never written
  assign wr_en     = accept && !ld_start && (state_reg == S_DATA) && last_byte
                     && ({1'b0, widx_reg} < DEPTH_W);

`ifdef INST_ROM_CKSUM_EN
  logic [7:0] cks_reg;
`else
  assign load_err_o = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_HDR0: if (accept) state_next = S_HDR1;
      S_HDR1: if (accept) state_next = (n_full != 16'd0) ? S_DATA : S_DONE;
      S_DATA: if (accept && last_byte && last_word) state_next = S_DONE;
`ifdef INST_ROM_CKSUM_EN
      S_CKS:  if (accept) state_next = (ld_data == cks_reg) ? S_RUN : S_ERR;
      S_ERR:  state_next = S_ERR;
`endif
      S_RUN:  state_next = S_RUN;
      default: state_next = S_HDR0;
    endcase
    if (ld_start) state_next = S_HDR0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_HDR0;
      count_reg      <= '0;
      widx_reg       <= '0;
      lane_reg       <= '0;
      shift_reg      <= '0;
      core_rst_o     <= 1'b1;
      load_done_o    <= 1'b0;
      words_loaded_o <= '0;
`ifdef INST_ROM_CKSUM_EN
      cks_reg        <= '0;
      load_err_o     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      // Status follows the next state so RUN entry lands on the final-byte edge
      core_rst_o  <= (state_next != S_RUN);
      load_done_o <= (state_next == S_RUN);
`ifdef INST_ROM_CKSUM_EN
      load_err_o  <= (state_next == S_ERR);
`endif
      if (ld_start) begin
        count_reg      <= '0;
        widx_reg       <= '0;
        lane_reg       <= '0;
        shift_reg      <= '0;
        words_loaded_o <= '0;
`ifdef INST_ROM_CKSUM_EN
        cks_reg        <= '0;
`endif
      end else if (accept) begin
        case (state_reg)
          S_HDR0: count_reg[15:8] <= ld_data;
          S_HDR1: count_reg[7:0]  <= ld_data;
          S_DATA: begin
            lane_reg  <= lane_reg + 2'd1;
            shift_reg <= {shift_reg[15:0], ld_data};
`ifdef INST_ROM_CKSUM_EN
            cks_reg   <= cks_reg ^ ld_data;
`endif
            if (last_byte) widx_reg <= widx_reg + 16'd1;
            if (wr_en) words_loaded_o <= words_loaded_o + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[widx_reg[ADDR_W-1:0]] <= {shift_reg, ld_data};
  end

  // Only the word-index bits select; upper and byte-offset bits are don't-care
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};

  assign rom_data_o = (rom_ce_i && !core_rst_o) ? mem[rom_addr_i[ADDR_W+1:2]] : 32'h0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: boot loads, fetch gating, restart, throttling,
// reset mid-load, array-end saturation and (with INST_ROM_CKSUM_EN) trailer checking.
module tb_inst_rom_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [7:0]  ld_data = 8'h00;
  logic        rom_ce_i = 1'b0;
  logic [31:0] rom_addr_i = 32'h0;
  logic [31:0] rom_data_o;
  logic        core_rst_o;
  logic        load_done_o;
  logic        load_err_o;
  logic [15:0] words_loaded_o;

  int checks = 0;
  int failures = 0;
  int gap_max = 0;

  inst_rom_loader #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
    .core_rst_o(core_rst_o), .load_done_o(load_done_o), .load_err_o(load_err_o),
    .words_loaded_o(words_loaded_o)
  );

  always #5 clk = ~clk;

  // All stimulus changes and samples happen 1ns after a rising edge
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    int gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    ld_valid = 1'b1;
    ld_data  = b;
    while (!ld_ready && t < 20) begin @(posedge clk); #1; t++; end
    checks++;
    if (ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_byte_timeout: ld_ready=%b required 1 for byte %h", ld_ready, b);
    end
    @(posedge clk); #1;
    ld_valid = 1'b0;
    $display("byte %h sent", b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    rom_ce_i = 1'b1;
    rom_addr_i = addr;
    #1;
    checks++;
    if (rom_data_o !== exp) begin
      failures++;
      $display("FAIL %s: addr=%h rom_data_o=%h required %h", name, addr, rom_data_o, exp);
    end else $display("read %s addr=%h data=%h", name, addr, rom_data_o);
  endtask

  task automatic stat_chk(input string name, input logic crst, input logic rdy,
                          input logic done, input logic err, input logic [15:0] wl);
    checks++;
    if ({core_rst_o, ld_ready, load_done_o, load_err_o, words_loaded_o} !== {crst, rdy, done, err, wl}) begin
      failures++;
      $display("FAIL %s: core_rst=%b ready=%b done=%b err=%b words=%0d required %b %b %b %b %0d",
               name, core_rst_o, ld_ready, load_done_o, load_err_o, words_loaded_o,
               crst, rdy, done, err, wl);
    end else $display("status %s ok", name);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rom_ce_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    stat_chk("reset_state", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    read_chk("read_in_reset", 32'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_load();
    send_hdr(16'd2);
    send_word(32'h34010001);
    send_byte(8'h34); send_byte(8'h02); send_byte(8'h00);
    stat_chk("after_7_bytes", 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
    send_byte(8'h02);
`ifdef INST_ROM_CKSUM_EN
    stat_chk("after_8_bytes_cks", 1'b1, 1'b1, 1'b0, 1'b0, 16'd2);
    send_byte(8'h00);
`endif
    stat_chk("basic_run", 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
    read_chk("basic_w0", 32'h0, 32'h34010001);
    read_chk("basic_w1", 32'h4, 32'h34020002);
  endtask

  task automatic test_read_gating();
    rom_ce_i = 1'b0;
    rom_addr_i = 32'h0;
    #1;
    checks++;
    if (rom_data_o !== 32'h0) begin
      failures++;
      $display("FAIL ce_low: rom_data_o=%h required 00000000", rom_data_o);
    end else $display("read ce_low data=%h", rom_data_o);
    read_chk("wrap_0x1000", 32'h00001000, 32'h34010001);
    read_chk("wrap_offset_0x1006", 32'hFFFF1006, 32'h34020002);
  endtask

  task automatic test_zero_len();
    pulse_start();
    send_hdr(16'd0);
`ifdef INST_ROM_CKSUM_EN
    stat_chk("zero_len_cks", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    send_byte(8'h00);
`endif
    stat_chk("zero_len_run", 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    read_chk("zero_len_stale", 32'h4, 32'h34020002);
  endtask

  task automatic test_restart();
    pulse_start();
    stat_chk("restart_state", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    // Byte offered in the same cycle as ld_start must be dropped
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'hFF;
    @(posedge clk); #1;
    ld_start = 1'b0; ld_valid = 1'b0;
    send_hdr(16'd1);
    send_word(32'hDEADBEEF);
`ifdef INST_ROM_CKSUM_EN
    send_byte(8'h22);
`endif
    stat_chk("restart_run", 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    read_chk("restart_w0", 32'h0, 32'hDEADBEEF);
    read_chk("restart_w1_kept", 32'h4, 32'h34020002);
  endtask

  task automatic test_throttled_and_reset();
    pulse_start();
    gap_max = 3;
    send_hdr(16'd3);
    send_word(32'h11223344);
    send_word(32'h55667788);
    send_word(32'h99AABBCC);
`ifdef INST_ROM_CKSUM_EN
    send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88 ^ 8'h99 ^ 8'hAA ^ 8'hBB ^ 8'hCC);
`endif
    gap_max = 0;
    stat_chk("throttled_run", 1'b0, 1'b0, 1'b1, 1'b0, 16'd3);
    read_chk("throttled_w0", 32'h0, 32'h11223344);
    read_chk("throttled_w1", 32'h4, 32'h55667788);
    read_chk("throttled_w2", 32'h8, 32'h99AABBCC);
    pulse_start();
    send_hdr(16'd2);
    send_word(32'hCAFEF00D);
    send_byte(8'hAA);
    rst = 1'b0;
    #2;
    stat_chk("async_rst_mid_data", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send_hdr(16'd1);
    send_word(32'h0BADC0DE);
`ifdef INST_ROM_CKSUM_EN
    send_byte(8'h0B ^ 8'hAD ^ 8'hC0 ^ 8'hDE);
`endif
    stat_chk("after_rst_reload", 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    read_chk("after_rst_w0", 32'h0, 32'h0BADC0DE);
    read_chk("after_rst_w1_stale", 32'h4, 32'h55667788);
  endtask

  task automatic test_saturation();
    logic [7:0] x = 8'h00;
    pulse_start();
    send_hdr(16'd1025);
    for (int i = 0; i <= 1024; i++) begin
      logic [15:0] v = 16'(i);
      send_word({16'hA5A5, v});
      x = x ^ v[15:8] ^ v[7:0];
    end
`ifdef INST_ROM_CKSUM_EN
    send_byte(x);
`endif
    stat_chk("saturation_run", 1'b0, 1'b0, 1'b1, 1'b0, 16'd1024);
    read_chk("saturation_w0_not_overwritten", 32'h0, 32'hA5A50000);
    read_chk("saturation_last", 32'hFFC, 32'hA5A503FF);
  endtask

`ifdef INST_ROM_CKSUM_EN
  task automatic test_checksum();
    pulse_start();
    send_hdr(16'd1);
    send_word(32'h01020304);
    send_byte(8'h04);
    stat_chk("cks_good", 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    read_chk("cks_good_w0", 32'h0, 32'h01020304);
    pulse_start();
    send_hdr(16'd1);
    send_word(32'h01020304);
    send_byte(8'h05);
    stat_chk("cks_bad", 1'b1, 1'b0, 1'b0, 1'b1, 16'd1);
    repeat (3) @(posedge clk);
    #1;
    stat_chk("cks_bad_held", 1'b1, 1'b0, 1'b0, 1'b1, 16'd1);
    read_chk("cks_bad_no_fetch", 32'h0, 32'h0);
    pulse_start();
    stat_chk("cks_err_exit", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_read_gating();
    test_zero_len();
    test_restart();
    test_throttled_and_reset();
    test_saturation();
`ifdef INST_ROM_CKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
